// File: rtl/cr16_exec_ctrl_if.sv
// ---------------------------------------------------------------------------
// cr16_exec_ctrl_if
// Bundle of the execution-controller signals exchanged with the board/core.
//   master : board/core side (drives controls, PC, buses; reads status)
//   slave  : cr16_exec_ctrl side
// Signals (controller view):
//   step_mode, step, resume, break_en, break_pc, pc, result_bus, mem_data_b,
//   display_sel                                              -> inputs
//   cr16_enable, halted, state, run_cycles, display_bits     -> outputs
//   trace_idx (in) / trace_pc (out) exist only when CR16_EXEC_CTRL_TRACE_EN
//   is defined.
// ---------------------------------------------------------------------------
interface cr16_exec_ctrl_if #(
    parameter int P_PC_WIDTH    = 16,
    parameter int P_COUNT_WIDTH = 24,
    parameter int P_NUM_DIGITS  = 6
);
    logic                        step_mode;
    logic                        step;
    logic                        resume;
    logic                        break_en;
    logic [P_PC_WIDTH-1:0]       break_pc;
    logic [P_PC_WIDTH-1:0]       pc;
    logic [15:0]                 result_bus;
    logic [15:0]                 mem_data_b;
    logic [1:0]                  display_sel;
    logic                        cr16_enable;
    logic                        halted;
    logic [1:0]                  state;
    logic [P_COUNT_WIDTH-1:0]    run_cycles;
    logic [4*P_NUM_DIGITS-1:0]   display_bits;
`ifdef CR16_EXEC_CTRL_TRACE_EN
    logic [2:0]                  trace_idx;
    logic [P_PC_WIDTH-1:0]       trace_pc;
`endif

    modport master (
`ifdef CR16_EXEC_CTRL_TRACE_EN
        output trace_idx,
        input  trace_pc,
`endif
        output step_mode, step, resume, break_en, break_pc, pc,
        output result_bus, mem_data_b, display_sel,
        input  cr16_enable, halted, state, run_cycles, display_bits
    );

    modport slave (
`ifdef CR16_EXEC_CTRL_TRACE_EN
        input  trace_idx,
        output trace_pc,
`endif
        input  step_mode, step, resume, break_en, break_pc, pc,
        input  result_bus, mem_data_b, display_sel,
        output cr16_enable, halted, state, run_cycles, display_bits
    );
endinterface

// File: rtl/cr16_exec_ctrl.sv
// ---------------------------------------------------------------------------
// cr16_exec_ctrl
// Execution controller between the CR16 core and the board I/O.
// FSM: WARMUP (BRAM settle) -> RUN / HALT, single-step (STEP) and resume,
// PC breakpoint halt. Drives the core enable (no clock gating), counts
// enabled cycles (saturating) and produces a registered 7-seg nibble word.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous, active-low reset
//   bus    : cr16_exec_ctrl_if.slave (controls, PC, buses, status, display)
//
// State code on bus.state: 00 WARMUP, 01 RUN, 10 STEP, 11 HALT.
// Display select: 00 mem_data_b, 01 {pc[7:0],result_bus}, 10 run_cycles,
//                 11 {state,pc}; zero-extended / MSB-truncated to 4*P_NUM_DIGITS.
//
// Optional feature: define CR16_EXEC_CTRL_TRACE_EN for an 8-entry PC trace
// ring (captures pc on every enabled cycle; trace_pc shows the entry written
// trace_idx+1 captures ago).
// ---------------------------------------------------------------------------
module cr16_exec_ctrl #(
    parameter int P_COLD_CLK_CYCLES = 2,
    parameter int P_STEP_CYCLES     = 3,
    parameter int P_PC_WIDTH        = 16,
    parameter int P_COUNT_WIDTH     = 24,
    parameter int P_NUM_DIGITS      = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    cr16_exec_ctrl_if.slave    bus
);
    localparam int WW    = (P_COLD_CLK_CYCLES > 1) ? $clog2(P_COLD_CLK_CYCLES) : 1;
    localparam int SW    = (P_STEP_CYCLES > 1) ? $clog2(P_STEP_CYCLES) : 1;
    localparam int DW    = 4 * P_NUM_DIGITS;
    localparam int M1    = (DW > 24) ? DW : 24;
    localparam int M2    = (M1 > P_COUNT_WIDTH) ? M1 : P_COUNT_WIDTH;
    localparam int SRC_W = (M2 > P_PC_WIDTH + 2) ? M2 : P_PC_WIDTH + 2;

    typedef enum logic [1:0] {
        S_WARMUP = 2'b00,
        S_RUN    = 2'b01,
        S_STEP   = 2'b10,
        S_HALT   = 2'b11
    } state_t;

    state_t                   state, state_n;
    logic [WW-1:0]            warm_cnt, warm_cnt_n;
    logic [SW-1:0]            step_cnt, step_cnt_n;
    logic                     skip_bp, skip_bp_n;
    logic                     step_q, resume_q;
    logic                     step_edge, resume_edge;
    logic                     bp_hit, enable;
    logic [P_COUNT_WIDTH-1:0] run_cycles;
    logic [DW-1:0]            disp;
    logic [SRC_W-1:0]         disp_src;

    // Edge detectors keep sampling in every state, so a level held high
    // through reset/warm-up never looks like a fresh request in HALT.
    assign step_edge   = bus.step   & ~step_q;
    assign resume_edge = bus.resume & ~resume_q;

    // skip_bp lets the instruction sitting on the breakpoint execute once
    // after a resume, otherwise the core could never move past it.
    assign bp_hit = bus.break_en && (bus.pc == bus.break_pc) && !skip_bp;
    assign enable = ((state == S_RUN) && !bp_hit) || (state == S_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_WARMUP;
            warm_cnt <= '0;
            step_cnt <= '0;
            skip_bp  <= 1'b0;
            step_q   <= 1'b0;
            resume_q <= 1'b0;
        end else begin
            state    <= state_n;
            warm_cnt <= warm_cnt_n;
            step_cnt <= step_cnt_n;
            skip_bp  <= skip_bp_n;
            step_q   <= bus.step;
            resume_q <= bus.resume;
        end
    end

    always_comb begin
        state_n    = state;
        warm_cnt_n = warm_cnt;
        step_cnt_n = step_cnt;
        skip_bp_n  = 1'b0;
        case (state)
            S_WARMUP: begin
                if (warm_cnt == WW'(P_COLD_CLK_CYCLES - 1)) begin
                    warm_cnt_n = '0;
                    state_n    = bus.step_mode ? S_HALT : S_RUN;
                end else begin
                    warm_cnt_n = warm_cnt + WW'(1);
                end
            end
            S_RUN: begin
                if (bp_hit || bus.step_mode)
                    state_n = S_HALT;
            end
            S_HALT: begin
                // Resume has priority over a simultaneous step when allowed.
                if (resume_edge && !bus.step_mode) begin
                    state_n   = S_RUN;
                    skip_bp_n = 1'b1;
                end else if (step_edge) begin
                    state_n    = S_STEP;
                    step_cnt_n = '0;
                end
            end
            S_STEP: begin
                if (step_cnt == SW'(P_STEP_CYCLES - 1)) begin
                    step_cnt_n = '0;
                    state_n    = S_HALT;
                end else begin
                    step_cnt_n = step_cnt + SW'(1);
                end
            end
            default: state_n = S_WARMUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            run_cycles <= '0;
        else if (enable && (run_cycles != '1))
            run_cycles <= run_cycles + P_COUNT_WIDTH'(1);
    end

    always_comb begin
        disp_src = '0;
        case (bus.display_sel)
            2'b00:   disp_src = SRC_W'(bus.mem_data_b);
            2'b01:   disp_src = SRC_W'({bus.pc[7:0], bus.result_bus});
            2'b10:   disp_src = SRC_W'(run_cycles);
            default: disp_src = SRC_W'({state, bus.pc});
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            disp <= '0;
        else
            disp <= disp_src[DW-1:0];
    end

    assign bus.cr16_enable  = enable;
    assign bus.halted       = (state == S_HALT);
    assign bus.state        = state;
    assign bus.run_cycles   = run_cycles;
    assign bus.display_bits = disp;

`ifdef CR16_EXEC_CTRL_TRACE_EN
    logic [P_PC_WIDTH-1:0] trace_buf [8];
    logic [2:0]            trace_wptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)
                trace_buf[i] <= '0;
            trace_wptr <= '0;
        end else if (enable) begin
            trace_buf[trace_wptr] <= bus.pc;
            trace_wptr            <= trace_wptr + 3'd1;
        end
    end

    // wptr-1 is the newest entry; 3-bit arithmetic wraps around the ring.
    assign bus.trace_pc = trace_buf[trace_wptr - 3'd1 - bus.trace_idx];
`endif
endmodule

// File: tb/tb_cr16_exec_ctrl.sv
module tb_cr16_exec_ctrl;
    localparam int COLD  = 2;
    localparam int STEPC = 3;
    localparam int RMAX  = (1 << 24) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cr16_exec_ctrl_if #(.P_PC_WIDTH(16), .P_COUNT_WIDTH(24), .P_NUM_DIGITS(6)) ifs ();
    cr16_exec_ctrl_if #(.P_PC_WIDTH(16), .P_COUNT_WIDTH(4),  .P_NUM_DIGITS(6)) ifs_sat ();

    cr16_exec_ctrl #(.P_COLD_CLK_CYCLES(COLD), .P_STEP_CYCLES(STEPC),
                     .P_PC_WIDTH(16), .P_COUNT_WIDTH(24), .P_NUM_DIGITS(6))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));

    cr16_exec_ctrl #(.P_COLD_CLK_CYCLES(COLD), .P_STEP_CYCLES(STEPC),
                     .P_PC_WIDTH(16), .P_COUNT_WIDTH(4), .P_NUM_DIGITS(6))
        u_sat (.clk(clk), .rst_n(rst_n), .bus(ifs_sat.slave));

    int ncomp = 0;
    int nfail = 0;

    // Reference model: phase uses the externally visible state code;
    // "left" counts remaining warm-up / step cycles.
    int          m_ph;
    int          m_left;
    bit          m_skip;
    bit          m_pstep, m_presume;
    int          m_runs;
    logic [23:0] m_disp;
    bit          core_sim = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        m_ph = 0; m_left = COLD; m_skip = 0;
        m_pstep = 0; m_presume = 0; m_runs = 0; m_disp = '0;
    endtask

    function automatic bit exp_en();
        bit bp;
        bp = ifs.break_en && (ifs.pc == ifs.break_pc) && !m_skip;
        return (m_ph == 1 && !bp) || (m_ph == 2);
    endfunction

    task automatic check_outputs();
        check("enable", {31'd0, ifs.cr16_enable}, {31'd0, exp_en()});
        check("halted", {31'd0, ifs.halted}, {31'd0, (m_ph == 3)});
        check("state", {30'd0, ifs.state}, 32'(m_ph));
        check("run_cycles", {8'd0, ifs.run_cycles}, 32'(m_runs));
        check("display", {8'd0, ifs.display_bits}, {8'd0, m_disp});
    endtask

    task automatic model_step(output bit en);
        bit se, re, bp;
        logic [23:0] nd;
        en = 0;
        if (!rst_n) begin do_reset(); return; end
        en = exp_en();
        bp = ifs.break_en && (ifs.pc == ifs.break_pc) && !m_skip;
        se = ifs.step && !m_pstep;
        re = ifs.resume && !m_presume;
        case (ifs.display_sel)
            2'b00:   nd = {8'd0, ifs.mem_data_b};
            2'b01:   nd = {ifs.pc[7:0], ifs.result_bus};
            2'b10:   nd = m_runs[23:0];
            default: nd = {6'd0, 2'(m_ph), ifs.pc};
        endcase
        if (en && m_runs != RMAX) m_runs++;
        m_pstep = ifs.step; m_presume = ifs.resume;
        m_skip = 0;
        case (m_ph)
            0: begin m_left--; if (m_left == 0) m_ph = ifs.step_mode ? 3 : 1; end
            1: if (bp || ifs.step_mode) m_ph = 3;
            3: if (re && !ifs.step_mode) begin m_ph = 1; m_skip = 1; end
               else if (se) begin m_ph = 2; m_left = STEPC; end
            default: begin m_left--; if (m_left == 0) m_ph = 3; end
        endcase
        m_disp = nd;
    endtask

    task automatic tick();
        bit en;
        @(negedge clk);
        check_outputs();
        model_step(en);
        @(posedge clk);
        #1;
        if (core_sim && en) ifs.pc = ifs.pc + 16'd1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        ifs.step_mode = 0; ifs.step = 0; ifs.resume = 0; ifs.break_en = 0;
        ifs.break_pc = '0; ifs.pc = '0; ifs.result_bus = 16'h1234;
        ifs.mem_data_b = 16'hBEEF; ifs.display_sel = 2'b00;
        ifs_sat.step_mode = 0; ifs_sat.step = 0; ifs_sat.resume = 0; ifs_sat.break_en = 0;
        ifs_sat.break_pc = '0; ifs_sat.pc = '0; ifs_sat.result_bus = '0;
        ifs_sat.mem_data_b = '0; ifs_sat.display_sel = 2'b10;
        do_reset();
        ticks(3);
        check("sat_reset", {28'd0, ifs_sat.run_cycles}, 32'd0);

        // Warm-up then free run with a breakpoint at 5
        ifs.break_en = 1; ifs.break_pc = 16'h0005; core_sim = 1;
        rst_n = 1;
        ticks(2);
        check("en_3rd_edge", {31'd0, ifs.cr16_enable}, 32'd1);
        check("state_run", {30'd0, ifs.state}, 32'd1);
        for (int i = 0; i < 30 && ifs.halted !== 1'b1; i++) tick();
        check("bp_halt", {31'd0, ifs.halted}, 32'd1);
        check("bp_pc", {16'd0, ifs.pc}, 32'd5);
        ticks(3);
        check("bp_pc_hold", {16'd0, ifs.pc}, 32'd5);

        // Resume past the breakpoint, then hit it again
        ifs.resume = 1; tick(); ifs.resume = 0;
        check("resume_en", {31'd0, ifs.cr16_enable}, 32'd1);
        ticks(4);
        ifs.pc = 16'd3;
        for (int i = 0; i < 20 && ifs.halted !== 1'b1; i++) tick();
        check("bp_again", {31'd0, ifs.halted}, 32'd1);
        check("bp_again_pc", {16'd0, ifs.pc}, 32'd5);

        // Step mode: three steps from a fresh reset
        rst_n = 0; do_reset(); ticks(2);
        ifs.break_en = 0; ifs.step_mode = 1; ifs.display_sel = 2'b10;
        rst_n = 1;
        for (int i = 0; i < 10 && ifs.halted !== 1'b1; i++) tick();
        check("sm_halt", {31'd0, ifs.halted}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            ifs.step = 1; tick(); ifs.step = 0;
            ticks(10);
        end
        check("step_runs", {8'd0, ifs.run_cycles}, 32'd9);

        // Simultaneous step+resume -> RUN; reset during STEP
        ifs.step_mode = 0;
        ifs.step = 1; ifs.resume = 1; tick(); ifs.step = 0; ifs.resume = 0;
        check("sim_run", {30'd0, ifs.state}, 32'd1);
        ifs.step_mode = 1; ticks(2);
        ifs.step = 1; tick(); ifs.step = 0;
        check("in_step", {30'd0, ifs.state}, 32'd2);
        tick();
        rst_n = 0; do_reset(); #1;
        check("rst_state", {30'd0, ifs.state}, 32'd0);
        check("rst_runs", {8'd0, ifs.run_cycles}, 32'd0);
        check("rst_en", {31'd0, ifs.cr16_enable}, 32'd0);
        ticks(2);
        ifs.step_mode = 0; rst_n = 1;

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            ifs.step_mode   = ($urandom_range(0, 9) == 0);
            ifs.step        = ($urandom_range(0, 3) == 0);
            ifs.resume      = ($urandom_range(0, 3) == 0);
            ifs.break_en    = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 15) == 0) ifs.break_pc = 16'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) ifs.pc = 16'($urandom_range(0, 7));
            ifs.display_sel = 2'($urandom_range(0, 3));
            ifs.mem_data_b  = 16'($urandom);
            ifs.result_bus  = 16'($urandom);
            if ($urandom_range(0, 149) == 0) begin rst_n = 0; do_reset(); end
            else rst_n = 1;
            tick();
        end

        // Saturation on the 4-bit counter instance after a clean free run
        rst_n = 1;
        ticks(25);
        check("sat_runs", {28'd0, ifs_sat.run_cycles}, 32'hF);
        check("sat_disp", {8'd0, ifs_sat.display_bits}, 32'h00000F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
